// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the channel scan sequencer.
// Widths here match the 4-to-16 decoder the index feeds.
package scan_pkg;

  localparam int CH_W    = 4;
  localparam int DWELL_W = 8;
  localparam int NUM_CH  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that times how long each channel is held.
// Load takes priority over decrement; the count parks at zero.
module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/channel_scan_sequencer.sv
// Steps a channel index through a latched range, holding each value for dwell+1
// cycles, in one-shot or continuous mode; all outputs are registered.
import scan_pkg::*;

module channel_scan_sequencer #(
  parameter int CH_W    = scan_pkg::CH_W,
  parameter int DWELL_W = scan_pkg::DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [CH_W-1:0]    first_ch,
  input  logic [CH_W-1:0]    last_ch,
  input  logic [DWELL_W-1:0] dwell,
  output logic [CH_W-1:0]    a,
  output logic               a_valid,
  output logic               busy,
  output logic               done
);

  state_t state_reg, state_next;

  logic [CH_W-1:0]    a_reg, a_next;
  logic               a_valid_reg, a_valid_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic [CH_W-1:0]    first_l_reg, last_l_reg;
  logic [DWELL_W-1:0] dwell_l_reg;
  logic               cont_l_reg;
  logic               latch;

  logic               timer_load, timer_en, timer_zero;
  logic [DWELL_W-1:0] timer_value;

  dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .en         (timer_en),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      a_valid_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      first_l_reg <= '0;
      last_l_reg  <= '0;
      dwell_l_reg <= '0;
      cont_l_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      a_valid_reg <= a_valid_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      if (latch) begin
        first_l_reg <= first_ch;
        last_l_reg  <= last_ch;
        dwell_l_reg <= dwell;
        cont_l_reg  <= cont;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    a_valid_next = a_valid_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    latch        = 1'b0;
    timer_load   = 1'b0;
    timer_en     = 1'b0;
    timer_value  = dwell_l_reg;

    case (state_reg)
      IDLE: begin
        // Start beats a simultaneous stop; stop has no meaning here.
        if (start) begin
          state_next   = SCAN;
          latch        = 1'b1;
          a_next       = first_ch;
          a_valid_next = 1'b1;
          busy_next    = 1'b1;
          timer_load   = 1'b1;
          timer_value  = dwell;
        end
      end
      SCAN: begin
        if (stop) begin
          state_next   = IDLE;
          a_valid_next = 1'b0;
          busy_next    = 1'b0;
        end else if (!timer_zero) begin
          timer_en = 1'b1;
        end else if (a_reg != last_l_reg) begin
          // Natural CH_W-bit overflow gives the 15 -> 0 wrap.
          a_next     = a_reg + 1'b1;
          timer_load = 1'b1;
        end else if (cont_l_reg) begin
          a_next     = first_l_reg;
          timer_load = 1'b1;
        end else begin
          state_next   = IDLE;
          a_valid_next = 1'b0;
          busy_next    = 1'b0;
          done_next    = 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        a_valid_next = 1'b0;
        busy_next    = 1'b0;
      end
    endcase
  end

  assign a       = a_reg;
  assign a_valid = a_valid_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// Directed and randomized checks of the channel scan sequencer against an
// expected-channel list built from the range/dwell rules.
module tb_channel_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, cont;
  logic [3:0] first_ch, last_ch;
  logic [7:0] dwell;
  logic [3:0] a;
  logic       a_valid, busy, done;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  channel_scan_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .cont     (cont),
    .first_ch (first_ch),
    .last_ch  (last_ch),
    .dwell    (dwell),
    .a        (a),
    .a_valid  (a_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Expected index stream for one pass: each channel repeated dwell+1 times,
  // walking upward modulo 16 from first to last.
  function automatic void build_pass(input int f, input int l, input int d);
    int ch;
    ch = f;
    forever begin
      for (int r = 0; r <= d; r++) exp_q.push_back(ch);
      if (ch == l) break;
      ch = (ch + 1) % 16;
    end
  endfunction

  task automatic begin_scan(input int f, input int l, input int d, input logic c);
    first_ch = 4'(f);
    last_ch  = 4'(l);
    dwell    = 8'(d);
    cont     = c;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic expect_active(input string tag, input int ch);
    check({tag, ".a"}, int'(a), ch);
    check({tag, ".a_valid"}, int'(a_valid), 1);
    check({tag, ".busy"}, int'(busy), 1);
    check({tag, ".done"}, int'(done), 0);
  endtask

  task automatic expect_idle(input string tag, input int ch, input int done_exp);
    check({tag, ".a"}, int'(a), ch);
    check({tag, ".a_valid"}, int'(a_valid), 0);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".done"}, int'(done), done_exp);
  endtask

  // Full one-shot scan; optionally pulses start with other settings mid-scan.
  task automatic one_shot(input string tag, input int f, input int l, input int d,
                          input int inject_at);
    exp_q.delete();
    build_pass(f, l, d);
    begin_scan(f, l, d, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      if (i == inject_at) begin
        first_ch = 4'd7;
        start    = 1'b1;
      end else begin
        start    = 1'b0;
      end
      expect_active(tag, exp_q[i]);
    end
    start = 1'b0;
    step();
    expect_idle({tag, ".end"}, l, 1);
    step();
    expect_idle({tag, ".after"}, l, 0);
  endtask

  initial begin
    logic [15:0] dec;
    rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0;
    first_ch = '0; last_ch = '0; dwell = '0;

    // Reset held for two cycles, with start asserted to show rst dominates
    start = 1'b1;
    step();
    step();
    expect_idle("reset", 0, 0);
    start = 1'b0;
    rst   = 1'b0;
    step();
    expect_idle("post_reset", 0, 0);

    one_shot("full_range", 0, 15, 0, -1);
    one_shot("range3_5", 3, 5, 2, -1);

    // Continuous wrap range 14..1, stopped while a=0 in the third pass
    exp_q.delete();
    build_pass(14, 1, 0);
    build_pass(14, 1, 0);
    exp_q.push_back(14);
    exp_q.push_back(15);
    exp_q.push_back(0);
    begin_scan(14, 1, 0, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      expect_active("cont_wrap", exp_q[i]);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    expect_idle("cont_stop", 0, 0);
    step();
    expect_idle("cont_stop_hold", 0, 0);

    // Single channel with a start pulse injected mid-scan
    one_shot("single9", 9, 9, 4, 2);

    // Reset during the dwell of channel 6
    exp_q.delete();
    build_pass(5, 8, 3);
    begin_scan(5, 8, 3, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) step();
      expect_active("rst_mid", exp_q[i]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_idle("rst_mid_after", 0, 0);
    dec = 16'h0001 << a;
    check("decoder_d", int'(dec), 16'h0001);
    step();
    expect_idle("rst_mid_idle", 0, 0);

    // Stop coinciding with the final dwell cycle of a one-shot pass
    exp_q.delete();
    build_pass(2, 3, 1);
    begin_scan(2, 3, 1, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      expect_active("stop_last", exp_q[i]);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    expect_idle("stop_last_end", 3, 0);
    step();
    expect_idle("stop_last_hold", 3, 0);

    // Start held high through the done cycle: rescan follows immediately
    exp_q.delete();
    build_pass(10, 11, 0);
    begin_scan(10, 11, 0, 1'b0);
    expect_active("restart", exp_q[0]);
    step();
    expect_active("restart", exp_q[1]);
    first_ch = 4'd4; last_ch = 4'd4; dwell = 8'd1; start = 1'b1;
    step();
    expect_idle("restart_done", 11, 1);
    step();
    start = 1'b0;
    expect_active("rescan", 4);
    step();
    expect_active("rescan", 4);
    step();
    expect_idle("rescan_done", 4, 1);

    // Randomized one-shot ranges and dwell times
    for (int n = 0; n < 10; n++) begin
      int f, l, d;
      f = int'($urandom_range(15, 0));
      l = int'($urandom_range(15, 0));
      d = int'($urandom_range(3, 0));
      one_shot($sformatf("rand%0d", n), f, l, d, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
